// File: rtl/pc_gen.sv
// Program counter generator: branch/jump target selection with misalignment
// trap and a circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int              PC_W      = 32,
  parameter int              XLEN      = 64,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] TRAP_PC   = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic [2:0]      br_type,
  input  logic            zero,
  input  logic            lt,
  input  logic            ltu,
  input  logic            jal,
  input  logic            jalr,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] immediate,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] next_pc,
  output logic            taken,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_mispredict
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  function automatic logic br_cond_f(input logic [2:0] f3, input logic z,
                                     input logic slt, input logic ult);
    logic c;
    case (f3)
      3'b000:  c = z;
      3'b001:  c = ~z;
      3'b100:  c = slt;
      3'b101:  c = ~slt;
      3'b110:  c = ult;
      3'b111:  c = ~ult;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic [PC_W-1:0]  ras_top;

  logic [XLEN-1:0]  pc_ext;
  logic [XLEN-1:0]  direct_sum;
  logic [PC_W-1:0]  direct_target;
  logic [PC_W-1:0]  jalr_target;
  logic [PC_W-1:0]  target;
  logic             branch_taken;
  logic             trap;
  logic             push;
  logic             pop;

  // ---- target selection (combinational) ----
  assign pc_plus4      = pc + PC_W'(4);
  assign pc_ext        = XLEN'(pc);
  assign direct_sum    = pc_ext + immediate;
  assign direct_target = direct_sum[PC_W-1:0];
  assign jalr_target   = {alu_result[PC_W-1:1], 1'b0};
  assign branch_taken  = branch & br_cond_f(br_type, zero, lt, ltu);

  always_comb begin
    target = pc_plus4;
    if (jalr)              target = jalr_target;
    else if (jal)          target = direct_target;
    else if (branch_taken) target = direct_target;
  end

  assign taken   = jalr | jal | branch_taken;
  assign trap    = taken & target[1];
  assign next_pc = trap ? TRAP_PC : target;

  // ---- return-address stack view ----
  assign top_idx   = ras_ptr - PTR_W'(1);
  assign ras_top   = ras_mem[top_idx];
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign push      = (jal | jalr) & is_call & ~trap;
  assign pop       = jalr & is_ret & ~trap;

  assign ras_mispredict = jalr & is_ret & (ras_empty | (ras_top != jalr_target));

  // ---- pc / control state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
    end else if (stall) begin
      misalign <= 1'b0;
    end else begin
      pc       <= next_pc;
      misalign <= trap;
      // A pop on an empty stack is a no-op, so push+pop there degrades to a push.
      if (push && pop && !ras_empty) begin
        ras_ptr <= ras_ptr;
      end else if (push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (pop && !ras_empty) begin
        ras_ptr <= ras_ptr - PTR_W'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

  // ---- RAS storage (data, no reset) ----
  always_ff @(posedge clk) begin
    if (rst_n && !stall && push) begin
      if (pop && !ras_empty) ras_mem[top_idx] <= pc_plus4;
      else                   ras_mem[ras_ptr] <= pc_plus4;
    end
  end

endmodule
